// File: rtl/gyro_frame_assembler.sv
// gyro_frame_assembler
// Turns the 6-byte gyro burst (X_hi, X_lo, Y_hi, Y_lo, Z_hi, Z_lo) into three
// signed 16-bit rates. A zero-rate bias is averaged over 2**CAL_SHIFT frames
// and then subtracted with saturation. Outputs stay at zero until calibration
// completes, and each sample is held until the next frame replaces it.

module gyro_frame_assembler #(
    parameter int CAL_SHIFT = 8
) (
    input  logic               clk_100mhz,
    input  logic               rst_in,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid_in,
    input  logic               frame_start_in,
    input  logic               recal_in,
    output logic signed [15:0] gx,
    output logic signed [15:0] gy,
    output logic signed [15:0] gz,
    output logic               sample_valid_out,
    output logic               calibrated_out,
    output logic               frame_err_out
);

    localparam int ACC_W = 16 + CAL_SHIFT;

    typedef enum logic [0:0] {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t                    state_r;
    logic [2:0]                byte_cnt_r;
    logic [39:0]               hold_r;      // bytes 0..4 of the frame being assembled
    logic [CAL_SHIFT-1:0]      frame_cnt_r;
    logic signed [ACC_W-1:0]   acc_x_r, acc_y_r, acc_z_r;
    logic signed [15:0]        bias_x_r, bias_y_r, bias_z_r;

    logic signed [15:0]        raw_x_s, raw_y_s, raw_z_s;
    logic signed [16:0]        diff_x_s, diff_y_s, diff_z_s;
    logic                      start_s, cont_s, done_s, last_cal_s;

    // Sign-extend a raw word to accumulator width.
    function automatic logic signed [ACC_W-1:0] widen(input logic signed [15:0] v);
        widen = {{CAL_SHIFT{v[15]}}, v};
    endfunction

    // Final bias: accumulator plus the last frame, arithmetic shift (floor).
    function automatic logic signed [15:0] cal_bias(input logic signed [ACC_W-1:0] acc,
                                                    input logic signed [15:0]      raw);
        logic signed [ACC_W-1:0] sum;
        logic signed [ACC_W-1:0] avg;
        sum      = acc + widen(raw);
        avg      = sum >>> CAL_SHIFT;
        cal_bias = avg[15:0];
    endfunction

    // Clamp a 17-bit difference into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            sat16 = v[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    // Byte classification, frame word extraction and bias subtraction.
    always_comb begin
        start_s    = byte_valid_in & frame_start_in;
        cont_s     = byte_valid_in & ~frame_start_in & (byte_cnt_r != 3'd0);
        done_s     = cont_s & (byte_cnt_r == 3'd5);
        last_cal_s = (frame_cnt_r == {CAL_SHIFT{1'b1}});
        raw_x_s    = hold_r[39:24];
        raw_y_s    = hold_r[23:8];
        raw_z_s    = {hold_r[7:0], byte_in};
        diff_x_s   = {raw_x_s[15], raw_x_s} - {bias_x_r[15], bias_x_r};
        diff_y_s   = {raw_y_s[15], raw_y_s} - {bias_y_r[15], bias_y_r};
        diff_z_s   = {raw_z_s[15], raw_z_s} - {bias_z_r[15], bias_z_r};
    end

    // Frame assembly, calibration accumulation and the CAL/RUN state machine.
    always_ff @(posedge clk_100mhz) begin
        if (rst_in) begin
            state_r          <= ST_CAL;
            byte_cnt_r       <= 3'd0;
            hold_r           <= 40'd0;
            frame_cnt_r      <= {CAL_SHIFT{1'b0}};
            acc_x_r          <= {ACC_W{1'b0}};
            acc_y_r          <= {ACC_W{1'b0}};
            acc_z_r          <= {ACC_W{1'b0}};
            bias_x_r         <= 16'sd0;
            bias_y_r         <= 16'sd0;
            bias_z_r         <= 16'sd0;
            gx               <= 16'sd0;
            gy               <= 16'sd0;
            gz               <= 16'sd0;
            sample_valid_out <= 1'b0;
            calibrated_out   <= 1'b0;
            frame_err_out    <= 1'b0;
        end else if (recal_in) begin
            // Recalibration beats any byte arriving this cycle; bias is kept
            // until the new calibration completes.
            state_r          <= ST_CAL;
            byte_cnt_r       <= 3'd0;
            frame_cnt_r      <= {CAL_SHIFT{1'b0}};
            acc_x_r          <= {ACC_W{1'b0}};
            acc_y_r          <= {ACC_W{1'b0}};
            acc_z_r          <= {ACC_W{1'b0}};
            gx               <= 16'sd0;
            gy               <= 16'sd0;
            gz               <= 16'sd0;
            sample_valid_out <= 1'b0;
            calibrated_out   <= 1'b0;
            frame_err_out    <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            frame_err_out    <= 1'b0;
            if (start_s) begin
                hold_r        <= {hold_r[31:0], byte_in};
                byte_cnt_r    <= 3'd1;
                frame_err_out <= (byte_cnt_r != 3'd0);
            end else if (done_s) begin
                byte_cnt_r <= 3'd0;
                case (state_r)
                    ST_CAL: begin
                        if (last_cal_s) begin
                            bias_x_r       <= cal_bias(acc_x_r, raw_x_s);
                            bias_y_r       <= cal_bias(acc_y_r, raw_y_s);
                            bias_z_r       <= cal_bias(acc_z_r, raw_z_s);
                            frame_cnt_r    <= {CAL_SHIFT{1'b0}};
                            calibrated_out <= 1'b1;
                            state_r        <= ST_RUN;
                        end else begin
                            acc_x_r     <= acc_x_r + widen(raw_x_s);
                            acc_y_r     <= acc_y_r + widen(raw_y_s);
                            acc_z_r     <= acc_z_r + widen(raw_z_s);
                            frame_cnt_r <= frame_cnt_r + {{(CAL_SHIFT-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_RUN: begin
                        gx               <= sat16(diff_x_s);
                        gy               <= sat16(diff_y_s);
                        gz               <= sat16(diff_z_s);
                        sample_valid_out <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_CAL;
                    end
                endcase
            end else if (cont_s) begin
                hold_r     <= {hold_r[31:0], byte_in};
                byte_cnt_r <= byte_cnt_r + 3'd1;
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end
        end
    end

endmodule
